// File: rtl/count_snapshot_fifo.sv
// -----------------------------------------------------------------------------
// count_snapshot_fifo
//
// Samples a free-running count into a small FIFO on each `capture` strobe and
// tags every sample with a flag that records whether the count wrapped
// (all-ones -> zero) since the previous accepted sample. Samples are presented
// to a reader over a valid/ready interface; captures that find the FIFO full
// are dropped and reported through a sticky overflow flag.
//
// Parameters
//   WIDTH  width of the sampled count
//   DEPTH  number of FIFO entries (power of two, >= 2)
//   AW     pointer width, derived from DEPTH
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   count_in   count value being monitored
//   capture    sample request, one sample per high cycle
//   out_data   head-entry count value (registered, holds when FIFO empties)
//   out_wrap   head-entry wrap tag
//   out_valid  FIFO non-empty
//   out_ready  reader accepts the head entry
//   level      current number of entries, 0..DEPTH
//   overflow   sticky: a capture was dropped
//   clear_ovf  clears overflow (a same-cycle drop takes priority)
// -----------------------------------------------------------------------------
module count_snapshot_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             capture,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wrap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             overflow,
  input  logic             clear_ovf
);

  localparam logic [AW:0]      FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;

  typedef struct packed {
    logic             wrap;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] prev_count;
  logic             wrap_pending;

  logic             wrap_det;
  logic             pop;
  logic             push;
  logic             drop;
  entry_t           push_entry;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      level_after_pop;
  logic [AW:0]      level_next;
  entry_t           head_next;

  // ---------------------------------------------------------------------------
  // Handshake decode and next-state arithmetic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a value on every path through the
  // block; leaving one unassigned on some path would infer a latch.
  always_comb begin
    // A wrap is seen only on the exact all-ones -> zero step; prev_count
    // resets to 0 so the first cycle after reset can never report one.
    wrap_det = (prev_count == ALL_ONES) && (count_in == '0);

    pop  = out_valid && out_ready;
    // A full FIFO still accepts a capture when the head leaves in the same
    // cycle, so a reader keeping up never causes a drop.
    push = capture && ((level != FULL_LEVEL) || pop);
    drop = capture && !push;

    // The tag covers a wrap seen in an earlier cycle (pending) as well as one
    // happening in the capture cycle itself.
    push_entry.wrap = wrap_pending | wrap_det;
    push_entry.data = count_in;

    rd_ptr_next     = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_after_pop = pop ? level - 1'b1 : level;
    level_next      = push ? level_after_pop + 1'b1 : level_after_pop;

    // The head after this edge is the entry being pushed when nothing else
    // remains; otherwise it is already sitting in storage at the new read
    // pointer.
    head_next = (level_after_pop == '0) ? push_entry : mem[rd_ptr_next];
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: storage is cleared on reset as well, so a read of any slot is
      // defined from the first cycle; this costs a reset net on each entry.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_wrap     <= 1'b0;
      overflow     <= 1'b0;
      prev_count   <= '0;
      wrap_pending <= 1'b0;
    end else begin
      prev_count <= count_in;

      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_next;
      level  <= level_next;

      // A successful push consumes any pending wrap; a dropped capture leaves
      // it in place for the next accepted sample.
      if (push) begin
        wrap_pending <= 1'b0;
      end else if (wrap_det) begin
        wrap_pending <= 1'b1;
      end

      // Registered head: refreshed whenever something remains, held when the
      // FIFO drains so the reader's last value stays visible.
      out_valid <= (level_next != '0);
      if (level_next != '0) begin
        out_data <= head_next.data;
        out_wrap <= head_next.wrap;
      end

      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// -----------------------------------------------------------------------------
// tb_count_snapshot_fifo
//
// Directed scenarios followed by a randomized run, all compared against a
// queue-based reference model of the sampling FIFO.
// -----------------------------------------------------------------------------
module tb_count_snapshot_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] count_in;
  logic             capture;
  logic [WIDTH-1:0] out_data;
  logic             out_wrap;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      level;
  logic             overflow;
  logic             clear_ovf;

  count_snapshot_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .capture   (capture),
    .out_data  (out_data),
    .out_wrap  (out_wrap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a queue of {wrap, data} entries plus the few flags the
  // sampling rules need.
  logic [WIDTH:0]   mq[$];
  logic [WIDTH:0]   m_head = '0;
  logic [WIDTH-1:0] m_prev = '0;
  logic             m_pend = 1'b0;
  logic             m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit wrapped;
    bit popped;
    bit accepted;
    if (!reset) begin
      mq.delete();
      m_head = '0;
      m_prev = '0;
      m_pend = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      wrapped  = (m_prev == 8'hFF) && (count_in == 8'h00);
      popped   = (mq.size() > 0) && out_ready;
      accepted = capture && ((mq.size() < DEPTH) || popped);
      if (popped) void'(mq.pop_front());
      if (accepted) begin
        mq.push_back({m_pend | wrapped, count_in});
        m_pend = 1'b0;
      end else begin
        m_pend = m_pend | wrapped;
      end
      if (capture && !accepted) m_ovf = 1'b1;
      else if (clear_ovf)       m_ovf = 1'b0;
      m_prev = count_in;
      if (mq.size() > 0) m_head = mq[0];
    end
  endtask

  // One clock edge: the model advances with the inputs held across the edge,
  // then every output is compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model.out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("model.level",     32'(level),     32'(mq.size()));
    check("model.out_data",  32'(out_data),  32'(m_head[WIDTH-1:0]));
    check("model.out_wrap",  32'(out_wrap),  32'(m_head[WIDTH]));
    check("model.overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic drive(input logic [7:0] cnt, input logic cap, input logic rdy, input logic clr);
    count_in  = cnt;
    capture   = cap;
    out_ready = rdy;
    clear_ovf = clr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] cnt;

    // 1. Reset with a capture pending: reset wins.
    reset = 1'b0;
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("reset.out_valid", 32'(out_valid), 32'h0);
    check("reset.level",     32'(level),     32'h0);
    check("reset.overflow",  32'(overflow),  32'h0);
    check("reset.out_data",  32'(out_data),  32'h00);
    check("reset.out_wrap",  32'(out_wrap),  32'h0);

    // 2. Single sample into an empty FIFO, stall, then pop.
    reset = 1'b1;
    drive(8'h2A, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h2B, 1'b0, 1'b0, 1'b0);
    check("single.out_valid", 32'(out_valid), 32'h1);
    check("single.out_data",  32'(out_data),  32'h2A);
    check("single.out_wrap",  32'(out_wrap),  32'h0);
    check("single.level",     32'(level),     32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(8'h2C + 8'(i), 1'b0, 1'b0, 1'b0);
      tick();
      check("stall.out_data", 32'(out_data), 32'h2A);
      check("stall.out_wrap", 32'(out_wrap), 32'h0);
    end
    drive(8'h30, 1'b0, 1'b1, 1'b0);
    tick();
    check("pop.out_valid", 32'(out_valid), 32'h0);
    check("pop.level",     32'(level),     32'h0);

    // 3. Wrap tagging: wrap seen earlier, then a clean sample, then a capture
    //    in the wrap cycle itself.
    cnt = 8'hFE;
    for (int i = 0; i < 6; i++) begin
      drive(cnt, (cnt == 8'h03), 1'b0, 1'b0);
      tick();
      cnt = cnt + 8'h01;
    end
    check("wrap.late.out_wrap", 32'(out_wrap), 32'h1);
    check("wrap.late.out_data", 32'(out_data), 32'h03);
    drive(8'h04, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h05, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h06, 1'b0, 1'b1, 1'b0);
    tick();
    check("wrap.clean.out_data", 32'(out_data), 32'h05);
    check("wrap.clean.out_wrap", 32'(out_wrap), 32'h0);
    tick();
    check("wrap.drained", 32'(out_valid), 32'h0);
    drive(8'hFE, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    check("wrap.same.out_wrap", 32'(out_wrap), 32'h1);
    check("wrap.same.out_data", 32'(out_data), 32'h00);
    drive(8'h01, 1'b0, 1'b1, 1'b0);
    tick();

    // 4. Fill, drop, drain in order, clear overflow.
    for (int i = 0; i < 5; i++) begin
      drive(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
      tick();
      if (i == 3) check("fill.level", 32'(level), 32'h4);
    end
    check("drop.overflow", 32'(overflow), 32'h1);
    check("drop.level",    32'(level),    32'h4);
    check("drop.head",     32'(out_data), 32'h10);
    for (int i = 1; i < 4; i++) begin
      drive(8'h20, 1'b0, 1'b1, 1'b0);
      tick();
      check("drain.order", 32'(out_data), 32'h10 + 32'(i));
    end
    tick();
    check("drain.empty",    32'(out_valid), 32'h0);
    check("drain.hold",     32'(out_data),  32'h13);
    check("drain.overflow", 32'(overflow),  32'h1);
    drive(8'h21, 1'b0, 1'b0, 1'b1);
    tick();
    check("clear.overflow", 32'(overflow), 32'h0);

    // 5. Push and pop together at full level: no drop.
    for (int i = 0; i < 4; i++) begin
      drive(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(8'h20, 1'b1, 1'b1, 1'b0);
    tick();
    check("fullpp.level",    32'(level),    32'h4);
    check("fullpp.overflow", 32'(overflow), 32'h0);
    check("fullpp.head",     32'(out_data), 32'h11);
    drive(8'h22, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    check("fullpp.last", 32'(out_data), 32'h20);
    tick();
    check("fullpp.empty", 32'(out_valid), 32'h0);

    // 6. Reset mid-operation with level 3, overflow set and a wrap pending.
    for (int i = 0; i < 5; i++) begin
      drive(8'h30 + 8'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_reset.level",    32'(level),    32'h3);
    check("pre_reset.overflow", 32'(overflow), 32'h1);
    reset = 1'b0;
    drive(8'h01, 1'b0, 1'b0, 1'b0);
    tick();
    check("mid_reset.level",     32'(level),     32'h0);
    check("mid_reset.out_valid", 32'(out_valid), 32'h0);
    check("mid_reset.overflow",  32'(overflow),  32'h0);
    check("mid_reset.out_data",  32'(out_data),  32'h00);
    reset = 1'b1;
    drive(8'h07, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_reset.out_data", 32'(out_data), 32'h07);
    check("post_reset.out_wrap", 32'(out_wrap), 32'h0);
    check("post_reset.level",    32'(level),    32'h1);

    // Randomized run: a mostly-incrementing count (frequent wraps), random
    // captures, reader stalls, overflow clears and occasional resets.
    cnt = 8'hF0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) cnt = 8'($urandom_range(255));
      else                        cnt = cnt + 8'h01;
      reset = ($urandom_range(99) != 0);
      drive(cnt, ($urandom_range(1) == 1), ($urandom_range(9) < 4),
            ($urandom_range(9) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
